// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    HUNT,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CSUM,
    EXEC,
    EXEC_RD,
    SEND_ACK,
    SEND_DATA,
    SEND_NAK
  } state_t;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_READ      = 8'h02;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

  // Expected checksum: writes cover the data byte, every other command does not.
  function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    if (cmd == CMD_WRITE) return cmd ^ addr ^ data;
    else                  return cmd ^ addr;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Gates byte writes into the UART TX buffer on its half-full flag and keeps
// at least one idle cycle between writes so the flag can catch up.
module uart_tx_arbiter (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic [7:0] i_byte,
  output logic       o_ack,
  input  logic       i_uart_tx_buffer_full,
  output logic       o_uart_tx_en,
  output logic [7:0] o_uart_tx_data
);

  logic gap_q;

  // Issue the requested byte when the buffer has room and the last cycle was idle;
  // reset suppresses the write in the very cycle it is asserted.
  always_comb begin
    o_uart_tx_en   = i_rst_n && i_req && !i_uart_tx_buffer_full && !gap_q;
    o_ack          = o_uart_tx_en;
    o_uart_tx_data = o_uart_tx_en ? i_byte : '0;
  end

  // Remember that a write just went out so the next cycle stays idle.
  always_ff @(posedge clk) begin
    if (!i_rst_n) gap_q <= 1'b0;
    else          gap_q <= o_uart_tx_en;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/CMD/ADDR/[DATA]/CSUM commands from the UART RX byte stream,
// drives an 8-bit register bus and answers ACK/NAK (+ read data) via UART TX.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [7:0]  ACK_BYTE    = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE    = DEF_NAK_BYTE,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_uart_rx_data,
  input  logic       i_uart_rx_data_valid,
  output logic       o_uart_tx_en,
  output logic [7:0] o_uart_tx_data,
  input  logic       i_uart_tx_buffer_full,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wr_data,
  output logic       o_reg_wr_en,
  output logic       o_reg_rd_en,
  input  logic [7:0] i_reg_rd_data,
  output logic       o_frame_err
);

  localparam int unsigned      CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, addr_q, data_q, rd_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_frame, expire, csum_ok, cmd_ok, is_write;
  logic             tx_req, tx_ack, err_d;
  logic [7:0]       tx_byte;

  uart_tx_arbiter u_tx_arb (
    .clk                   (clk),
    .i_rst_n               (i_rst_n),
    .i_req                 (tx_req),
    .i_byte                (tx_byte),
    .o_ack                 (tx_ack),
    .i_uart_tx_buffer_full (i_uart_tx_buffer_full),
    .o_uart_tx_en          (o_uart_tx_en),
    .o_uart_tx_data        (o_uart_tx_data)
  );

  // Frame checks and the inter-byte timeout condition.
  always_comb begin
    in_frame = state_q inside {GET_CMD, GET_ADDR, GET_DATA, GET_CSUM};
    is_write = (cmd_q == CMD_WRITE);
    cmd_ok   = is_write || (cmd_q == CMD_READ);
    csum_ok  = (i_uart_rx_data == frame_csum(cmd_q, addr_q, data_q));
    expire   = in_frame && !i_uart_rx_data_valid && (cnt_q == CNT_MAX);
  end

  // Next-state, register strobes, TX requests and error pulse source.
  always_comb begin
    state_d     = state_q;
    tx_req      = 1'b0;
    tx_byte     = '0;
    o_reg_wr_en = 1'b0;
    o_reg_rd_en = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      HUNT:
        if (i_uart_rx_data_valid && i_uart_rx_data == SYNC_BYTE) state_d = GET_CMD;
      GET_CMD:
        if (i_uart_rx_data_valid) state_d = GET_ADDR;
      GET_ADDR:
        if (i_uart_rx_data_valid) state_d = is_write ? GET_DATA : GET_CSUM;
      GET_DATA:
        if (i_uart_rx_data_valid) state_d = GET_CSUM;
      GET_CSUM:
        if (i_uart_rx_data_valid) begin
          if (csum_ok && cmd_ok) begin
            state_d = EXEC;
          end else begin
            state_d = SEND_NAK;
            err_d   = 1'b1;
          end
        end
      EXEC:
        if (is_write) begin
          o_reg_wr_en = 1'b1;
          state_d     = SEND_ACK;
        end else begin
          o_reg_rd_en = 1'b1;
          state_d     = EXEC_RD;
        end
      EXEC_RD:
        state_d = SEND_ACK;
      SEND_ACK: begin
        tx_req  = 1'b1;
        tx_byte = ACK_BYTE;
        if (tx_ack) state_d = is_write ? HUNT : SEND_DATA;
      end
      SEND_DATA: begin
        tx_req  = 1'b1;
        tx_byte = rd_data_q;
        if (tx_ack) state_d = HUNT;
      end
      SEND_NAK: begin
        tx_req  = 1'b1;
        tx_byte = NAK_BYTE;
        if (tx_ack) state_d = HUNT;
      end
      default:
        state_d = HUNT;
    endcase

    // Partial frame abandoned silently apart from the error pulse.
    if (expire) begin
      state_d = HUNT;
      err_d   = 1'b1;
    end

    // Bytes landing while busy executing or responding are dropped.
    if (i_uart_rx_data_valid && !in_frame && state_q != HUNT) err_d = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // Field capture, bus outputs, read-data capture, timeout counter and error pulse.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      rd_data_q     <= '0;
      cnt_q         <= '0;
      o_reg_addr    <= '0;
      o_reg_wr_data <= '0;
      o_frame_err   <= 1'b0;
    end else begin
      o_frame_err <= err_d;

      if (!in_frame || i_uart_rx_data_valid || expire) cnt_q <= '0;
      else                                             cnt_q <= cnt_q + CNT_W'(1);

      if (i_uart_rx_data_valid) begin
        if (state_q == GET_CMD)  cmd_q  <= i_uart_rx_data;
        if (state_q == GET_ADDR) addr_q <= i_uart_rx_data;
        if (state_q == GET_DATA) data_q <= i_uart_rx_data;
      end

      // Bus address/data only move for accepted frames so they hold between strobes.
      if (state_q == GET_CSUM && state_d == EXEC) begin
        o_reg_addr <= addr_q;
        if (is_write) o_reg_wr_data <= data_q;
      end

      if (state_q == EXEC_RD) rd_data_q <= i_reg_rd_data;
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Byte-level command parser sitting directly downstream of the UART receive path; upstream of the UART transmit path for responses.
- Consumes received bytes (data + 1-cycle valid strobe), frames fixed-format commands and checks them, then drives a simple 8-bit register bus.
- Returns ACK/NAK (and read data) as byte writes into the UART TX buffer, honouring its half-full flag.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- ACK_BYTE, 8'h06, response for an accepted command
- NAK_BYTE, 8'h15, response for bad checksum or unknown command
- TIMEOUT_CYC, 1_000_000, max clk cycles between bytes inside a frame before abort

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  synchronous reset, active-low
- i_uart_rx_data  in  8  received byte
- i_uart_rx_data_valid  in  1  one-cycle strobe; i_uart_rx_data valid in the same cycle
- o_uart_tx_en  out  1  one-cycle write strobe into the TX buffer
- o_uart_tx_data  out  8  byte to transmit; valid when o_uart_tx_en=1
- i_uart_tx_buffer_full  in  1  TX buffer half-full; no write may be issued while it is 1
- o_reg_addr  out  8  register address
- o_reg_wr_data  out  8  write data
- o_reg_wr_en  out  1  one-cycle write strobe
- o_reg_rd_en  out  1  one-cycle read strobe
- i_reg_rd_data  in  8  read data, valid exactly 1 cycle after o_reg_rd_en
- o_frame_err  out  1  one-cycle pulse on NAK, timeout or dropped byte

Behaviour:
- Reset (i_rst_n=0 at a clk edge):
  - all outputs go to 0, state to HUNT, timeout counter to 0.
  - Reset mid-frame or mid-response abandons it; no further TX write is issued.
- Frame format: SYNC, CMD, ADDR, [DATA if CMD=8'h01], CSUM.
  - CMD 8'h01 = write; CMD 8'h02 = read.
  - CSUM = CMD ^ ADDR ^ DATA for a write; CMD ^ ADDR for a read.
- States:
  - HUNT: bytes other than SYNC_BYTE are discarded silently. SYNC -> GET_CMD.
  - GET_CMD -> GET_ADDR. A CMD that is not 01/02 is still framed as a read-length frame and NAKed at GET_CSUM.
  - GET_ADDR -> GET_DATA for a write, else -> GET_CSUM.
  - GET_DATA -> GET_CSUM.
  - GET_CSUM:
    - checksum good and CMD valid -> EXEC.
    - otherwise -> SEND_NAK, and o_frame_err pulses.
  - EXEC:
    - write: o_reg_wr_en pulses one cycle with the latched addr/data, then -> SEND_ACK.
    - read: o_reg_rd_en pulses, next cycle i_reg_rd_data is captured, then -> SEND_ACK.
    - Register-bus latency: the strobe is issued in the cycle after the CSUM byte's valid strobe.
  - SEND_ACK: issue ACK_BYTE. A read then goes -> SEND_DATA (captured byte); a write goes -> HUNT.
  - SEND_NAK: issue NAK_BYTE -> HUNT.
- TX handshake:
  - A write is issued only in a cycle where i_uart_tx_buffer_full=0.
  - Consecutive writes are separated by at least one idle cycle, so the full flag can update.
  - Waiting on full is unbounded; no timeout applies while waiting.
- Bytes that arrive while in EXEC/SEND_* are dropped and o_frame_err pulses. The parser does not resynchronise on a dropped byte.
- Timeout:
  - The counter clears on every valid byte and runs only in GET_* states.
  - When it reaches TIMEOUT_CYC-1: -> HUNT, o_frame_err pulses, no response is sent, and the partial frame is discarded.
  - A byte arriving in the same cycle as expiry wins: it is consumed and the counter clears.
- SYNC_BYTE appearing inside a frame is treated as ordinary data; there is no mid-frame resync.
- o_reg_addr/o_reg_wr_data hold their last latched values between strobes.

Decomposition:
- Shared package uart_cmd_pkg:
  - state enum
  - CMD_WRITE=8'h01, CMD_READ=8'h02
  - default SYNC/ACK/NAK constants
- One natural sub-module, uart_tx_arbiter: owns the tx_buffer_full gating and the idle-cycle spacing, and accepts a byte-request/ack handshake from the FSM.
- Everything else stays in a single FSM file.

Test Plan:
1. Write frame A5 01 10 3C 2D -> one o_reg_wr_en pulse with addr=10, data=3C; then exactly one TX byte 06; no o_frame_err.
2. Read frame A5 02 20 22, with i_reg_rd_data=5A -> one o_reg_rd_en pulse with addr=20; then TX bytes 06, 5A in that order.
3. Bad checksum A5 01 10 3C 00 -> no reg strobe; TX byte 15; o_frame_err pulses once. Follow with a good frame -> that frame is accepted.
4. Noise 00 FF 13 followed by frame 1 -> the noise is ignored and frame 1 is executed exactly as in scenario 1.
5. Send A5 01, then idle for TIMEOUT_CYC cycles (TIMEOUT_CYC set to 50 in the bench) -> o_frame_err pulses, no TX, parser back in HUNT. Frame 1 afterwards -> accepted.
6. Hold i_uart_tx_buffer_full=1 for 200 cycles during the read in scenario 2 -> no o_uart_tx_en until it drops, then 06 and 5A are sent with at least 1 idle cycle between them. Asserting i_rst_n=0 during the wait -> no TX at all.
